wb_sram_arbiter: RTL and testbench
==================================

Name: wb_sram_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter placed in front of the SRAM wrapper on interconnect slave port 0.
- Master 0 is the management-SoC path from the interconnect. Master 1 is the on-chip UART/DMA path.
- Arbitration is round-robin and per transaction. A grant is held from request until slave ack or master cycle drop.
- Ensures exactly one master drives the SRAM at a time and no master observes another master's ack or data.

Parameters:
- ADDR_WD, 9, SRAM word-address width on all address ports.
- DATA_WD, 32, data width; sel width is DATA_WD/8.
- TIMEOUT_CYC, 255, cycles a granted strobe may wait for ack before abort (used only with the optional feature). Must be ≥ 2.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- m0_wb_cyc_i / m1_wb_cyc_i  in  1  master bus cycle.
- m0_wb_stb_i / m1_wb_stb_i  in  1  master strobe.
- m0_wb_we_i / m1_wb_we_i  in  1  write enable.
- m0_wb_adr_i / m1_wb_adr_i  in  ADDR_WD  word address.
- m0_wb_dat_i / m1_wb_dat_i  in  DATA_WD  write data.
- m0_wb_sel_i / m1_wb_sel_i  in  DATA_WD/8  byte enables.
- m0_wb_dat_o / m1_wb_dat_o  out  DATA_WD  read data; 0 when that master is not granted.
- m0_wb_ack_o / m1_wb_ack_o  out  1  ack, gated by grant.
- m0_wb_err_o / m1_wb_err_o  out  1  timeout error pulse.
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1  slave control.
- s_wb_adr_o  out  ADDR_WD  slave address.
- s_wb_dat_o  out  DATA_WD  slave write data.
- s_wb_sel_o  out  DATA_WD/8  slave byte enables.
- s_wb_dat_i  in  DATA_WD  slave read data.
- s_wb_ack_i  in  1  slave ack.
- gnt_o  out  2  one-hot current grant {m1,m0}; 00 when idle.

Behaviour:
- Reset, sampled on the rising edge:
  - state=IDLE, last_gnt=M1 (so M0 wins the first tie).
  - All outputs are 0.
  - Timeout counter cleared.
- FSM states: IDLE, GNT0, GNT1.
- Request for master X is reqX = mX_cyc_i & mX_stb_i.
- IDLE transitions:
  - req0 & !req1 → GNT0.
  - req1 & !req0 → GNT1.
  - Both requesting → grant the master that is not last_gnt.
  - Neither → stay in IDLE.
  - last_gnt updates on entry to a grant state.
- Grant takes one cycle: request seen at edge N, gnt_o and slave cycle asserted after edge N.
- While in GNTx:
  - s_wb_* is combinationally driven from master x.
  - s_wb_cyc_o = mx_cyc_i and s_wb_stb_o = mx_stb_i.
  - mx_wb_ack_o = s_wb_ack_i; mx_wb_dat_o = s_wb_dat_i.
  - The other master sees ack=0 and dat=0; it stalls by simply holding its stb.
- While in IDLE: s_wb_cyc_o=s_wb_stb_o=s_wb_we_o=0; adr, dat and sel are 0.
- Release from GNTx: s_wb_ack_i & mx_stb_i at edge → IDLE.
  - The following cycle always re-arbitrates, giving a one-cycle bubble.
  - Back-to-back SRAM access therefore alternates fairly when both masters request.
- mx_cyc_i falling in GNTx (abort) → IDLE at the next edge. A slave ack in that same cycle is still forwarded.
- A slave ack while IDLE is ignored and is not forwarded to either master.
- Reset asserted mid-transaction: at that edge the FSM returns to IDLE and slave cyc drops. The pending master never receives ack.
- gnt_o is registered, one-hot or zero, and never 11.

Optional Feature:
- Macro: WB_SRAM_ARB_TIMEOUT_EN.
- With the macro:
  - An 8..16-bit counter, sized to clog2(TIMEOUT_CYC+1), clears on grant entry.
  - It increments each GNTx cycle with stb high and no ack.
  - When it reaches TIMEOUT_CYC, mx_wb_err_o pulses high for one cycle and the FSM returns to IDLE (slave cyc drops at that edge).
  - last_gnt is kept, so the other master is favoured next.
- Without the macro: no counter is instantiated, both err outputs are tied to 0, and the TIMEOUT_CYC parameter is unused.

Decomposition:
- Package wb_arb_pkg holds:
  - the state enum (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10);
  - the master index constants M0=1'b0, M1=1'b1;
  - the function computing counter width from TIMEOUT_CYC.
- One sub-module, wb_arb_timeout: counter with clear/enable/expire ports. It is instantiated only under WB_SRAM_ARB_TIMEOUT_EN.
- Muxing and the FSM stay in the top.

Test Plan:
- Reset, then m0 write adr=9'h010, dat=32'hDEADBEEF, sel=4'hF; slave acks 1 cycle after stb → gnt_o=01 one cycle after req, s_wb_adr_o=9'h010, m0 ack one pulse, m1_ack=0, back to IDLE.
- Both masters request in the same cycle after reset → M0 granted first. After M0's ack there is a 1-cycle IDLE, then M1 is granted. Repeat 4× → grants strictly alternate 0,1,0,1.
- M1 read adr=9'h1F8; slave returns 32'h12345678 with ack → m1_wb_dat_o=32'h12345678 in the ack cycle; m0_wb_dat_o=0 throughout.
- M0 granted, then drops cyc before ack → IDLE next edge. A subsequent M1 request is granted and s_wb_cyc_o has no glitch to M0 values.
- wb_rst_i asserted while GNT1 with stb high → next edge: gnt_o=00, s_wb_cyc_o=0, m1 ack never asserted; after release, M0 wins the first tie.
- With WB_SRAM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, slave never acks an M0 read → m0_wb_err_o pulses once, 8 cycles after grant, FSM goes IDLE, and a waiting M1 is granted next. Without the macro, the same stimulus gives err=0 and the grant is held indefinitely.

Source files
------------

// File: rtl/wb_sram_arbiter_pkg.sv
// Shared types and helpers for the two-master Wishbone SRAM arbiter.
// Holds the FSM state encoding, master indices and the timeout counter width rule.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Counter wide enough to hold TIMEOUT_CYC, kept within 8..16 bits.
    function automatic int timeout_cnt_w(input int timeout_cyc);
        int w;
        w = $clog2(timeout_cyc + 1);
        if (w < 8) w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/wb_sram_arbiter_if.sv
// Wishbone classic bus bundle; master modport is the initiator side,
// slave modport the target side.
interface wb_sram_arbiter_if #(
    parameter int ADDR_WD = 9,
    parameter int DATA_WD = 32
) ();
    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [ADDR_WD-1:0]     adr;
    logic [DATA_WD-1:0]     dat_w;
    logic [DATA_WD/8-1:0]   sel;
    logic [DATA_WD-1:0]     dat_r;
    logic                   ack;
    logic                   err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_sram_arbiter_timeout.sv
// Grant watchdog: counts stalled strobe cycles and flags the cycle in which
// the count would reach TIMEOUT_CYC.
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = timeout_cnt_w(TIMEOUT_CYC)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYC-th stalled cycle so the abort lands on that edge.
    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/wb_sram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SRAM wrapper.
// Optional grant timeout enabled by defining WB_SRAM_ARB_TIMEOUT_EN.
module wb_sram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WD     = 9,
    parameter int DATA_WD     = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    wb_sram_arbiter_if.slave         m0,
    wb_sram_arbiter_if.slave         m1,
    wb_sram_arbiter_if.master        s,
    output logic [1:0]               gnt_o
);

    arb_state_e state, state_nxt;
    logic       last_gnt, last_gnt_nxt;
    logic       req0, req1;
    logic       sel_cyc, sel_stb;
    logic       expire;

    assign req0 = m0.cyc & m0.stb;
    assign req1 = m1.cyc & m1.stb;

    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        unique case (state)
            GNT0: begin
                sel_cyc = m0.cyc;
                sel_stb = m0.stb;
            end
            GNT1: begin
                sel_cyc = m1.cyc;
                sel_stb = m1.stb;
            end
            default: ;
        endcase
    end

`ifdef WB_SRAM_ARB_TIMEOUT_EN
    logic to_en;

    assign to_en = (state != IDLE) && sel_stb && !s.ack;

    wb_arb_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (state == IDLE),
        .en     (to_en),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            last_gnt <= M1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Every release passes through IDLE, so the next pick is always a fresh arbitration.
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = (last_gnt == M0) ? GNT1 : GNT0;
                end else if (req0) begin
                    state_nxt = GNT0;
                end else if (req1) begin
                    state_nxt = GNT1;
                end
                if (state_nxt == GNT0) begin
                    last_gnt_nxt = M0;
                end else if (state_nxt == GNT1) begin
                    last_gnt_nxt = M1;
                end
            end
            GNT0, GNT1: begin
                if (!sel_cyc || (s.ack && sel_stb) || expire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt_o = {state == GNT1, state == GNT0};

    // Slave side follows the granted master; the loser sees a silent bus.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = {ADDR_WD{1'b0}};
        s.dat_w  = {DATA_WD{1'b0}};
        s.sel    = {(DATA_WD/8){1'b0}};
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.dat_r = {DATA_WD{1'b0}};
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.dat_r = {DATA_WD{1'b0}};
        case (state)
            GNT0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
                s.we     = m0.we;
                s.adr    = m0.adr;
                s.dat_w  = m0.dat_w;
                s.sel    = m0.sel;
                m0.ack   = s.ack;
                m0.dat_r = s.dat_r;
                m0.err   = expire;
            end
            GNT1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
                s.we     = m1.we;
                s.adr    = m1.adr;
                s.dat_w  = m1.dat_w;
                s.sel    = m1.sel;
                m1.ack   = s.ack;
                m1.dat_r = s.dat_r;
                m1.err   = expire;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Bench for wb_sram_arbiter: directed vector table, corner sequences and
// randomized traffic against a transaction-level ownership model.
module tb_wb_sram_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [DW-1:0] RD = 32'h12345678;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;

    wb_sram_arbiter_if #(.ADDR_WD(AW), .DATA_WD(DW)) m0_bus ();
    wb_sram_arbiter_if #(.ADDR_WD(AW), .DATA_WD(DW)) m1_bus ();
    wb_sram_arbiter_if #(.ADDR_WD(AW), .DATA_WD(DW)) s_bus ();

    wb_sram_arbiter #(
        .ADDR_WD     (AW),
        .DATA_WD     (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0       (m0_bus),
        .m1       (m1_bus),
        .s        (s_bus),
        .gnt_o    (gnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          rst, c0, s0, c1, s1, ack;
        logic [1:0]    gnt;
        logic          scyc, ack0, ack1;
        logic [AW-1:0] sadr;
        logic [DW-1:0] dat0, dat1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, c0, s0, c1, s1, a, logic [1:0] g,
                               logic sc, a0, a1, logic [AW-1:0] ad,
                               logic [DW-1:0] d0, d1);
        vec_t t;
        t.rst = r;  t.c0 = c0; t.s0 = s0; t.c1 = c1; t.s1 = s1; t.ack = a;
        t.gnt = g;  t.scyc = sc; t.ack0 = a0; t.ack1 = a1;
        t.sadr = ad; t.dat0 = d0; t.dat1 = d1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, c0, s0, c1, s1, a);
        rst          = r;
        m0_bus.cyc   = c0;
        m0_bus.stb   = s0;
        m1_bus.cyc   = c1;
        m1_bus.stb   = s1;
        s_bus.ack    = a;
        s_bus.dat_r  = a ? RD : '0;
    endtask

    // Reference model: who owns the SRAM, who was served last, stalled cycles.
    int own, last_own, wcnt;

    task automatic model_edge();
        logic r0, r1, cx, sx;
        int   nxt;
        if (rst) begin
            own = -1; last_own = 1; wcnt = 0;
            return;
        end
        r0  = m0_bus.cyc && m0_bus.stb;
        r1  = m1_bus.cyc && m1_bus.stb;
        nxt = own;
        if (own < 0) begin
            if (r0 && r1)  nxt = (last_own == 0) ? 1 : 0;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
            if (nxt >= 0) begin
                last_own = nxt;
                wcnt     = 0;
            end
        end else begin
            cx = (own == 0) ? m0_bus.cyc : m1_bus.cyc;
            sx = (own == 0) ? m0_bus.stb : m1_bus.stb;
            if (!cx || (s_bus.ack && sx)) begin
                nxt = -1;
            end else if (sx && !s_bus.ack) begin
                wcnt++;
`ifdef WB_SRAM_ARB_TIMEOUT_EN
                if (wcnt >= TO) nxt = -1;
`endif
            end
        end
        own = nxt;
    endtask

    function automatic logic exp_err(int who);
`ifdef WB_SRAM_ARB_TIMEOUT_EN
        logic sx;
        sx = (who == 0) ? m0_bus.stb : m1_bus.stb;
        return (own == who) && sx && !s_bus.ack && (wcnt == TO - 1);
`else
        return (who < 0);
`endif
    endfunction

    task automatic rand_drive(input logic force_rst);
        rst           = force_rst || ($urandom_range(99) < 3);
        m0_bus.cyc    = ($urandom_range(3) != 0);
        m0_bus.stb    = ($urandom_range(3) != 0);
        m0_bus.we     = 1'($urandom);
        m0_bus.adr    = AW'($urandom);
        m0_bus.dat_w  = $urandom;
        m0_bus.sel    = 4'($urandom);
        m1_bus.cyc    = ($urandom_range(3) != 0);
        m1_bus.stb    = ($urandom_range(3) != 0);
        m1_bus.we     = 1'($urandom);
        m1_bus.adr    = AW'($urandom);
        m1_bus.dat_w  = $urandom;
        m1_bus.sel    = 4'($urandom);
        s_bus.ack     = ($urandom_range(9) < 4);
        s_bus.dat_r   = $urandom;
    endtask

    task automatic rand_check(input int i);
        logic [63:0] es, e0, e1, eg;
        es = '0; e0 = '0; e1 = '0;
        eg = (own < 0) ? 64'd0 : (own == 0 ? 64'd1 : 64'd2);
        if (own == 0) begin
            es = {m0_bus.cyc, m0_bus.stb, m0_bus.we, m0_bus.adr, m0_bus.dat_w, m0_bus.sel};
            e0 = {s_bus.ack, exp_err(0), s_bus.dat_r};
        end else if (own == 1) begin
            es = {m1_bus.cyc, m1_bus.stb, m1_bus.we, m1_bus.adr, m1_bus.dat_w, m1_bus.sel};
            e1 = {s_bus.ack, exp_err(1), s_bus.dat_r};
        end
        chk($sformatf("rnd%0d gnt", i), gnt, eg);
        chk($sformatf("rnd%0d slave", i),
            {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.dat_w, s_bus.sel}, es);
        chk($sformatf("rnd%0d m0", i), {m0_bus.ack, m0_bus.err, m0_bus.dat_r}, e0);
        chk($sformatf("rnd%0d m1", i), {m1_bus.ack, m1_bus.err, m1_bus.dat_r}, e1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int err0_cnt, err1_cnt, err0_at;
        logic [1:0] g_hist[1:20];

        m0_bus.we = 1'b1; m0_bus.adr = 9'h010; m0_bus.dat_w = 32'hDEADBEEF; m0_bus.sel = 4'hF;
        m1_bus.we = 1'b0; m1_bus.adr = 9'h1F8; m1_bus.dat_w = '0;           m1_bus.sel = 4'hF;
        s_bus.err = 1'b0;

        // reset, M0 write
        tbl.push_back(v(1,0,0,0,0,0, 2'b00,0,0,0, 9'h000, 0, 0));
        tbl.push_back(v(0,1,1,0,0,0, 2'b00,0,0,0, 9'h000, 0, 0));
        tbl.push_back(v(0,1,1,0,0,0, 2'b01,1,0,0, 9'h010, 0, 0));
        tbl.push_back(v(0,1,1,0,0,1, 2'b01,1,1,0, 9'h010, RD, 0));
        tbl.push_back(v(0,0,0,0,0,0, 2'b00,0,0,0, 9'h000, 0, 0));
        // reset, then both request: strict alternation with bubbles
        tbl.push_back(v(1,1,1,1,1,0, 2'b00,0,0,0, 9'h000, 0, 0));
        tbl.push_back(v(0,1,1,1,1,0, 2'b00,0,0,0, 9'h000, 0, 0));
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tbl.push_back(v(0,1,1,1,1,0, 2'b00,0,0,0, 9'h000, 0, 0));
            tbl.push_back(v(0,1,1,1,1,1, 2'b01,1,1,0, 9'h010, RD, 0));
            tbl.push_back(v(0,1,1,1,1,0, 2'b00,0,0,0, 9'h000, 0, 0));
            tbl.push_back(v(0,1,1,1,1,1, 2'b10,1,0,1, 9'h1F8, 0, RD));
        end
        // M1 read, then a stray slave ack while idle
        tbl.push_back(v(0,0,0,0,0,0, 2'b00,0,0,0, 9'h000, 0, 0));
        tbl.push_back(v(0,0,0,1,1,0, 2'b00,0,0,0, 9'h000, 0, 0));
        tbl.push_back(v(0,0,0,1,1,0, 2'b10,1,0,0, 9'h1F8, 0, 0));
        tbl.push_back(v(0,0,0,1,1,1, 2'b10,1,0,1, 9'h1F8, 0, RD));
        tbl.push_back(v(0,0,0,0,0,1, 2'b00,0,0,0, 9'h000, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack);
            @(negedge clk);
            chk($sformatf("row%0d gnt", i),  gnt,          tbl[i].gnt);
            chk($sformatf("row%0d scyc", i), s_bus.cyc,    tbl[i].scyc);
            chk($sformatf("row%0d sadr", i), s_bus.adr,    tbl[i].sadr);
            chk($sformatf("row%0d ack0", i), m0_bus.ack,   tbl[i].ack0);
            chk($sformatf("row%0d ack1", i), m1_bus.ack,   tbl[i].ack1);
            chk($sformatf("row%0d dat0", i), m0_bus.dat_r, tbl[i].dat0);
            chk($sformatf("row%0d dat1", i), m1_bus.dat_r, tbl[i].dat1);
            step();
        end

        // M0 aborts; an ack in the abort cycle still reaches M0
        drive(0,1,1,0,0,0); step();
        chk("abort gnt0", gnt, 2'b01);
        drive(0,0,0,1,1,1); #1;
        chk("abort ack fwd", m0_bus.ack, 1'b1);
        chk("abort m1 no ack", m1_bus.ack, 1'b0);
        chk("abort scyc follows", s_bus.cyc, 1'b0);
        drive(0,0,0,1,1,0); step();
        chk("abort idle gnt", gnt, 2'b00);
        chk("abort idle scyc", s_bus.cyc, 1'b0);
        chk("abort idle sadr", s_bus.adr, 9'h000);
        step();
        chk("abort m1 gnt", gnt, 2'b10);
        chk("abort m1 scyc", s_bus.cyc, 1'b1);
        chk("abort m1 sadr", s_bus.adr, 9'h1F8);

        // reset while M1 holds the grant
        drive(1,0,0,1,1,0); step();
        chk("rst gnt", gnt, 2'b00);
        chk("rst scyc", s_bus.cyc, 1'b0);
        drive(1,0,0,1,1,1); #1;
        chk("rst m1 no ack", m1_bus.ack, 1'b0);
        drive(0,1,1,1,1,0); step();
        chk("rst tie m0", gnt, 2'b01);

        drive(0,0,0,0,0,0); step(); step();

        // M0 read never acked while M1 waits
        drive(0,1,1,0,0,0); step();
        chk("to gnt0", gnt, 2'b01);
        drive(0,1,1,1,1,0);
        err0_cnt = 0; err1_cnt = 0; err0_at = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            g_hist[k] = gnt;
            if (m0_bus.err) begin err0_cnt++; err0_at = k; end
            if (m1_bus.err) err1_cnt++;
            step();
        end
`ifdef WB_SRAM_ARB_TIMEOUT_EN
        chk("to err0 count", err0_cnt, 1);
        chk("to err0 cycle", err0_at, 8);
        chk("to idle after", g_hist[9], 2'b00);
        chk("to m1 next", g_hist[10], 2'b10);
        chk("to err1 count", err1_cnt, 1);
`else
        chk("to err0 count", err0_cnt, 0);
        chk("to err1 count", err1_cnt, 0);
        chk("to held early", g_hist[9], 2'b01);
        chk("to held late", g_hist[20], 2'b01);
`endif

        own = -1; last_own = 1; wcnt = 0;
        for (int i = 0; i < 400; i++) begin
            rand_drive(i == 0);
            @(negedge clk);
            if (i > 0) rand_check(i);
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
